// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch
// Description : Instruction fetch prefetch queue. Issues one word-aligned
//               fetch request at a time, stores {pc, instr} pairs in a
//               DEPTH-entry circular FIFO and presents the head to the
//               consumer. A redirect flushes the queue and restarts fetch;
//               a request still in flight at redirect time is drained and
//               its data discarded.
//               Optional build macro: ARVI_FETCH_PERF_EN adds empty-cycle
//               and redirect counters (o_perf_empty_cnt, o_perf_flush_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_ex_inst_addr
`ifdef ARVI_FETCH_PERF_EN
    ,
    output logic [31:0]     o_perf_empty_cnt,
    output logic [31:0]     o_perf_flush_cnt
`endif
);

    localparam int                  c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);
    localparam logic [XLEN-1:0]     c_step  = XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_mem_req;
    logic [XLEN-1:0]      r_req_addr;
    logic [XLEN-1:0]      r_pend_addr;
    logic                 r_ex;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [XLEN-1:0]      r_fifo_pc    [DEPTH];
    logic [XLEN-1:0]      r_fifo_instr [DEPTH];

    logic [XLEN-1:0]      w_redirect_aligned;
    logic                 w_pop;
    logic                 w_push;
    logic [c_cnt_w-1:0]   w_count_next;
    logic                 w_has_room;

    // Redirect targets are always fetched from the word-aligned address.
    assign w_redirect_aligned = {i_redirect_pc[XLEN-1:2], 2'b00};

    // Redirect wins over both pop and push in the same cycle.
    assign w_pop  = (r_count != '0) && i_ready && !i_redirect;
    assign w_push = (r_state == S_BUSY) && i_mem_ready && !i_redirect;

    // Occupancy after this edge; drives the decision to keep fetching.
    always_comb begin
        w_count_next = r_count;
        if (i_redirect) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    assign w_has_room = (w_count_next < c_depth);

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // FIFO storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
            r_fifo_instr[r_wr_ptr] <= i_mem_data;
        end
    end

    // Fetch controller: one outstanding request, drain-and-drop after a
    // redirect that arrives while memory is still stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_req_addr  <= PC_RESET;
            r_pend_addr <= PC_RESET;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_redirect) begin
                        r_req_addr <= w_redirect_aligned;
                        r_state    <= S_BUSY;
                        r_mem_req  <= 1'b1;
                    end else if (w_has_room) begin
                        r_state    <= S_BUSY;
                        r_mem_req  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (i_redirect) begin
                        if (i_mem_ready) begin
                            r_req_addr  <= w_redirect_aligned;
                        end else begin
                            r_pend_addr <= w_redirect_aligned;
                            r_state     <= S_DISCARD;
                        end
                    end else if (i_mem_ready) begin
                        r_req_addr <= r_req_addr + c_step;
                        if (!w_has_room) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (i_mem_ready) begin
                        r_req_addr <= i_redirect ? w_redirect_aligned : r_pend_addr;
                        r_state    <= S_BUSY;
                    end else if (i_redirect) begin
                        r_pend_addr <= w_redirect_aligned;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Misaligned-target exception flag, high for the cycle after the redirect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex <= 1'b0;
        end else begin
            r_ex <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
        end
    end

    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_req_addr;
    assign o_valid        = (r_count != '0);
    assign o_pc           = r_fifo_pc[r_rd_ptr];
    assign o_instr        = r_fifo_instr[r_rd_ptr];
    assign o_ex_inst_addr = r_ex;

`ifdef ARVI_FETCH_PERF_EN
    logic [31:0] r_perf_empty;
    logic [31:0] r_perf_flush;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_empty <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!o_valid) begin
                r_perf_empty <= r_perf_empty + 32'd1;
            end
            if (i_redirect) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign o_perf_empty_cnt = r_perf_empty;
    assign o_perf_flush_cnt = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch
// Description : Self-checking bench for if_prefetch. Directed scenarios plus
//               a randomized run, all compared against a transaction-level
//               model of the expected instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              o_mem_req;
    logic [XLEN-1:0]   o_mem_addr;
    logic              i_mem_ready;
    logic [XLEN-1:0]   i_mem_data;
    logic              o_valid;
    logic [XLEN-1:0]   o_instr;
    logic [XLEN-1:0]   o_pc;
    logic              i_ready;
    logic              i_redirect;
    logic [XLEN-1:0]   i_redirect_pc;
    logic              o_ex_inst_addr;
`ifdef ARVI_FETCH_PERF_EN
    logic [31:0]       o_perf_empty_cnt;
    logic [31:0]       o_perf_flush_cnt;
`endif

    if_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RST)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ready    (i_mem_ready),
        .i_mem_data     (i_mem_data),
        .o_valid        (o_valid),
        .o_instr        (o_instr),
        .o_pc           (o_pc),
        .i_ready        (i_ready),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_ex_inst_addr (o_ex_inst_addr)
`ifdef ARVI_FETCH_PERF_EN
        ,
        .o_perf_empty_cnt (o_perf_empty_cnt),
        .o_perf_flush_cnt (o_perf_flush_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the PCs the queue should hold, the next useful fetch
    // address, and whether the bus currently carries an abandoned request.
    logic [31:0] q[$];
    logic [31:0] next_addr;
    bit          stale;
    logic [31:0] stale_addr;
    bit          exp_ex;
    bit          exp_req;
    int unsigned exp_empty;
    int unsigned exp_flush;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_ready       = 1'b0;
        i_mem_ready   = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_mem_data    = '0;
        repeat (2) @(negedge i_clk);
        check("rst_req",   o_mem_req,      1'b0);
        check("rst_valid", o_valid,        1'b0);
        check("rst_ex",    o_ex_inst_addr, 1'b0);
        check("rst_addr",  o_mem_addr,     PC_RST);
`ifdef ARVI_FETCH_PERF_EN
        check("rst_perf_empty", o_perf_empty_cnt, 32'd0);
        check("rst_perf_flush", o_perf_flush_cnt, 32'd0);
`endif
        i_rst = 1'b0;
        q.delete();
        next_addr = PC_RST;
        stale     = 1'b0;
        stale_addr = '0;
        exp_ex    = 1'b0;
        exp_req   = 1'b0;
        exp_empty = 0;
        exp_flush = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model by what this edge should do.
    task automatic cycle(input bit rdy, input bit mrdy, input bit redir, input logic [31:0] rpc);
        bit          hs;
        bit          pop;
        logic [31:0] bus;
        i_ready       = rdy;
        i_mem_ready   = mrdy;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_mem_data    = mrdy ? mem_word(o_mem_addr) : $urandom;
        #1;
        check("valid", o_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("pc",    o_pc,    q[0]);
            check("instr", o_instr, mem_word(q[0]));
        end
        check("ex",  o_ex_inst_addr, exp_ex);
        check("req", o_mem_req,      exp_req);
        bus = stale ? stale_addr : next_addr;
        if (o_mem_req) check("addr", o_mem_addr, bus);
        if (q.size() == 0) exp_empty++;

        hs  = o_mem_req && mrdy;
        pop = (q.size() != 0) && rdy && !redir;
        if (pop) void'(q.pop_front());
        if (redir) begin
            exp_flush++;
            q.delete();
            if (o_mem_req && !mrdy) begin
                stale      = 1'b1;
                stale_addr = bus;
            end else begin
                stale = 1'b0;
            end
            next_addr = {rpc[31:2], 2'b00};
        end else if (hs) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                q.push_back(next_addr);
                next_addr = next_addr + 32'd4;
            end
        end
        exp_ex  = redir && (rpc[1:0] != 2'b00);
        exp_req = (exp_req && !mrdy) || redir || (q.size() < DEPTH);
        @(negedge i_clk);
    endtask

    initial begin
        // Reset, first request timing and sustained streaming.
        do_reset();
        check("first_cycle_req", o_mem_req, 1'b0);
        cycle(1, 1, 0, 0);
        check("second_cycle_req", o_mem_req, 1'b1);
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stream_valid", o_valid, 1'b1);
            check("stream_pc",    o_pc,    PC_RST + 32'(4 * k));
            cycle(1, 1, 0, 0);
        end

        // Consumer stalled: queue fills, fetch idles, one pop restarts it.
        do_reset();
        repeat (8) cycle(0, 1, 0, 0);
        #1;
        check("full_idle_req", o_mem_req, 1'b0);
        check("full_head_pc",  o_pc,      PC_RST);
        cycle(1, 0, 0, 0);
        #1;
        check("refill_req",  o_mem_req,  1'b1);
        check("refill_addr", o_mem_addr, 32'h0000_0110);
        cycle(0, 1, 0, 0);

        // Redirect while memory is stalled: old data dropped.
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h0000_0200);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        #1;
        check("discard_addr", o_mem_addr, PC_RST);
        cycle(1, 1, 0, 0);
        #1;
        check("redir_addr",  o_mem_addr, 32'h0000_0200);
        check("redir_empty", o_valid,    1'b0);
        cycle(1, 1, 0, 0);
        #1;
        check("redir_pc", o_pc, 32'h0000_0200);
        cycle(1, 1, 0, 0);

        // Misaligned redirect target.
        cycle(1, 1, 1, 32'h0000_0302);
        #1;
        check("ex_pulse",   o_ex_inst_addr, 1'b1);
        check("ex_aligned", o_mem_addr,     32'h0000_0300);
        cycle(1, 1, 0, 0);
        #1;
        check("ex_clear", o_ex_inst_addr, 1'b0);
        check("ex_pc",    o_pc,           32'h0000_0300);
        cycle(1, 1, 0, 0);

        // Redirect colliding with a pop and a push.
        #1;
        check("collide_pre_valid", o_valid, 1'b1);
        cycle(1, 1, 1, 32'h0000_0400);
        #1;
        check("collide_flushed", o_valid, 1'b0);
        repeat (3) cycle(1, 1, 0, 0);

        // Address wrap at the top of the address space.
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        repeat (4) cycle(1, 1, 0, 0);

        // Reset asserted in the middle of a stalled request.
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        #1;
        check("pre_async_req", o_mem_req, 1'b1);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_rst_req",   o_mem_req, 1'b0);
        check("async_rst_valid", o_valid,   1'b0);
        i_mem_ready = 1'b1;
        i_mem_data  = $urandom;
        @(negedge i_clk);
        do_reset();
        repeat (6) cycle(1, 1, 0, 0);

        // Event counters over a short known sequence.
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_0500);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_0600);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
`ifdef ARVI_FETCH_PERF_EN
        check("perf_empty_dir", o_perf_empty_cnt, 32'd5);
        check("perf_flush_dir", o_perf_flush_cnt, 32'd2);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) < 6,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0,
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
        end
`ifdef ARVI_FETCH_PERF_EN
        check("perf_empty_rand", o_perf_empty_cnt, exp_empty);
        check("perf_flush_rand", o_perf_flush_cnt, exp_flush);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-003 SHALL have parameter PC_RESET, default 32'h0000_0000, first fetch address.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide these ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- o_mem_req  out  1  fetch request, held until i_mem_ready.
- o_mem_addr  out  XLEN  word-aligned fetch address.
- i_mem_ready  in  1  i_mem_data valid this cycle; completes the request.
- i_mem_data  in  XLEN  fetched instruction word.
- o_valid  out  1  queue head valid.
- o_instr  out  XLEN  head instruction.
- o_pc  out  XLEN  head PC.
- i_ready  in  1  consumer takes the head when o_valid is high.
- i_redirect  in  1  flush the queue and restart fetch.
- i_redirect_pc  in  XLEN  restart target.
- o_ex_inst_addr  out  1  one-cycle pulse: redirect target misaligned.

Function
REQ-006 SHALL store {pc, instr} pairs in a DEPTH-entry circular FIFO with wrap-around read/write pointers and a count of 0..DEPTH.
REQ-007 SHALL drive o_valid = (count != 0), with o_instr/o_pc from the head entry combinationally.
REQ-008 SHALL pop the head on a rising edge when o_valid && i_ready && !i_redirect.
REQ-009 SHALL have states IDLE, BUSY and DISCARD, with at most one request outstanding.
REQ-010 IDLE: o_mem_req=0; go to BUSY next cycle if count_next < DEPTH.
REQ-011 BUSY: o_mem_req=1 and o_mem_addr=req_addr, held stable.
- On i_mem_ready: push {req_addr, i_mem_data}, set req_addr += 4.
- Stay in BUSY if count after push/pop is < DEPTH, else go to IDLE.
REQ-012 Pop and push in the same cycle SHALL leave count unchanged; a push never occurs while count == DEPTH.
REQ-013 Redirect in IDLE, or in BUSY with i_mem_ready=1: discard any returning data, flush the FIFO (count=0), set req_addr={i_redirect_pc[XLEN-1:2],2'b00}, go to BUSY.
REQ-014 Redirect in BUSY with i_mem_ready=0: flush the FIFO, latch the new target into pend_addr, go to DISCARD; o_mem_addr keeps the old address.
REQ-015 DISCARD: o_mem_req=1 with the old address.
- On i_mem_ready: drop the data, set req_addr=pend_addr, go to BUSY.
- A further redirect overwrites pend_addr.
REQ-016 Redirect SHALL have priority over push and pop in the same cycle; o_valid=0 in the following cycle.
REQ-017 o_ex_inst_addr SHALL be 1 for exactly the cycle after a redirect with i_redirect_pc[1:0] != 0; fetch still proceeds from the aligned address.
REQ-018 Redirect-to-first-valid latency SHALL be 2 cycles with zero-wait memory.
REQ-019 Sustained throughput SHALL be 1 instruction/cycle with zero-wait memory and i_ready held high.
REQ-020 req_addr increment SHALL wrap modulo 2^XLEN.

Reset
REQ-021 While i_rst=1:
- state=IDLE, count=0, pointers=0.
- req_addr=PC_RESET.
- o_mem_req=0, o_valid=0, o_ex_inst_addr=0.
REQ-022 Reset asserted mid-request SHALL abandon the request immediately; data returned afterwards SHALL be ignored.
REQ-023 The first request SHALL be issued in the second cycle after reset release.

Configuration
REQ-024 With macro ARVI_FETCH_PERF_EN defined, the block SHALL add:
- o_perf_empty_cnt  out  32: counts cycles with o_valid=0 and i_rst=0.
- o_perf_flush_cnt  out  32: counts redirects.
- Both counters reset to 0 and wrap at 2^32.
REQ-025 Without ARVI_FETCH_PERF_EN, these ports and counters SHALL be absent.

Verification
REQ-026 Reset with PC_RESET=0x100, zero-wait memory, i_ready=1 -> o_pc 0x100, 0x104, 0x108 on consecutive cycles.
REQ-027 i_ready=0, DEPTH=4 -> exactly 4 pushes, then IDLE with o_mem_req=0; one pop -> one new request, to address 0x110.
REQ-028 Redirect to 0x200 while BUSY with memory stalled 3 cycles -> old data dropped, next o_mem_addr=0x200, first o_pc=0x200.
REQ-029 Redirect to 0x302 -> o_ex_inst_addr pulses one cycle, fetch from 0x300.
REQ-030 Redirect in the same cycle as a pop and an i_mem_ready push -> count=0 next cycle, no stale entry appears on o_pc.
REQ-031 With ARVI_FETCH_PERF_EN: 2 redirects and 5 empty cycles -> o_perf_flush_cnt=2, o_perf_empty_cnt=5.
